// File: rtl/lsu_mem_arbiter_pkg.sv
// rtl/lsu_mem_arbiter_pkg.sv - shared types and widths for the LSU memory arbiter
//
// Purpose: arbiter FSM state encoding and the address/data widths used by the
// interface, the picker and the arbiter top.
package mem_arb_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WR,
        ARB_RD_WAIT
    } arb_state_t;

endpackage

// File: rtl/lsu_mem_arbiter_if.sv
// rtl/lsu_mem_arbiter_if.sv - requester and memory bus bundle for the LSU memory arbiter
//
// Purpose: groups the NUM_REQ requester ports and the single memory port.
// Signals:
//   req_ren/req_raddr     level read request per requester, address
//   req_rvalid/req_rdata  read-data pulse per requester, broadcast read data
//   req_wen/req_waddr/req_wdata  level write request per requester
//   req_wack              write-accepted pulse per requester
//   mem_ren/mem_raddr     memory read enable (level) and address
//   mem_rvalid/mem_rdata  memory read response
//   mem_wen/mem_waddr/mem_wdata  memory write pulse, address, data
// Modports: slave = arbiter view, master = requesters plus memory model view.
interface lsu_mem_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import mem_arb_pkg::*;

    logic [NUM_REQ-1:0] req_ren;
    logic [ADDR_W-1:0]  req_raddr [NUM_REQ];
    logic [NUM_REQ-1:0] req_rvalid;
    logic [DATA_W-1:0]  req_rdata [NUM_REQ];
    logic [NUM_REQ-1:0] req_wen;
    logic [ADDR_W-1:0]  req_waddr [NUM_REQ];
    logic [DATA_W-1:0]  req_wdata [NUM_REQ];
    logic [NUM_REQ-1:0] req_wack;

    logic               mem_ren;
    logic [ADDR_W-1:0]  mem_raddr;
    logic               mem_rvalid;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_wen;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;

    modport slave (
        input  req_ren, req_raddr, req_wen, req_waddr, req_wdata,
        output req_rvalid, req_rdata, req_wack,
        output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
        input  mem_rvalid, mem_rdata
    );

    modport master (
        output req_ren, req_raddr, req_wen, req_waddr, req_wdata,
        input  req_rvalid, req_rdata, req_wack,
        input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
        output mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/lsu_mem_arbiter_rr_pick.sv
// rtl/lsu_mem_arbiter_rr_pick.sv - combinational round-robin priority picker
//
// Purpose: returns the first set bit of pending at or after rr_ptr, wrapping.
// Ports:
//   pending  in  NUM_REQ   requester pending vector
//   rr_ptr   in  ID_BITS   highest-priority index this cycle (always < NUM_REQ)
//   any      out 1         at least one requester pending
//   grant    out ID_BITS   chosen index (0 when any is low)
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [ID_BITS-1:0] rr_ptr,
    output logic               any,
    output logic [ID_BITS-1:0] grant
);

    // Scan from the farthest offset down to offset 0 so the closest pending
    // index to rr_ptr is the last one written and therefore wins.
    always_comb begin
        int idx;
        idx   = 0;
        any   = 1'b0;
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (pending[idx]) begin
                any   = 1'b1;
                grant = ID_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// rtl/lsu_mem_arbiter.sv - round-robin arbiter sharing one data-memory port among requesters
//
// Purpose: grants one requester at a time, at most one memory transaction in
// flight. Writes take one cycle; reads hold mem_ren until mem_rvalid.
// Ports:
//   clk       in  1        clock
//   rst       in  1        asynchronous active-high reset
//   bus       slave        requester and memory signals (lsu_mem_arbiter_if)
//   grant_id  out ID_BITS  current or last granted requester
//   busy      out 1        transaction in flight (state != IDLE)
module lsu_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_BITS = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    lsu_mem_arbiter_if.slave   bus,
    output logic [ID_BITS-1:0] grant_id,
    output logic               busy
);

    arb_state_t         state, state_nxt;
    logic [ID_BITS-1:0] rr_ptr;
    logic [ID_BITS-1:0] pick_id;
    logic [ID_BITS-1:0] rr_next;
    logic               pick_any;
    logic [NUM_REQ-1:0] pending;
    logic [ADDR_W-1:0]  raddr_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [DATA_W-1:0]  wdata_q;

    assign pending = bus.req_ren | bus.req_wen;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_BITS (ID_BITS)
    ) u_rr_pick (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .any     (pick_any),
        .grant   (pick_id)
    );

    assign rr_next = (pick_id == ID_BITS'(NUM_REQ - 1)) ? '0 : pick_id + ID_BITS'(1);

    // State register plus the grant/address/data capture taken on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && pick_any) begin
                grant_id <= pick_id;
                rr_ptr   <= rr_next;
                if (bus.req_wen[pick_id]) begin
                    waddr_q <= bus.req_waddr[pick_id];
                    wdata_q <= bus.req_wdata[pick_id];
                end else begin
                    raddr_q <= bus.req_raddr[pick_id];
                end
            end
        end
    end

    // A write wins over a read from the same requester.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_nxt = bus.req_wen[pick_id] ? ARB_WR : ARB_RD_WAIT;
                end
            end
            ARB_WR:      state_nxt = ARB_IDLE;
            ARB_RD_WAIT: if (bus.mem_rvalid) state_nxt = ARB_IDLE;
            default:     state_nxt = ARB_IDLE;
        endcase
    end

    // Outputs decode the state flop only; mem_rvalid -> req_rvalid is the
    // single combinational path through the block.
    always_comb begin
        bus.mem_ren    = 1'b0;
        bus.mem_wen    = 1'b0;
        bus.req_wack   = '0;
        bus.req_rvalid = '0;
        busy           = (state != ARB_IDLE);
        case (state)
            ARB_WR: begin
                bus.mem_wen            = 1'b1;
                bus.req_wack[grant_id] = 1'b1;
            end
            ARB_RD_WAIT: begin
                bus.mem_ren              = 1'b1;
                bus.req_rvalid[grant_id] = bus.mem_rvalid;
            end
            default: ;
        endcase
    end

    assign bus.mem_raddr = raddr_q;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdata
        assign bus.req_rdata[i] = bus.mem_rdata;
    end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb/tb_lsu_mem_arbiter.sv - directed self-checking bench for lsu_mem_arbiter
module tb_lsu_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] grant_id;
    logic       busy;
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cnt0, cnt1;

    lsu_mem_arbiter_if #(.NUM_REQ(2)) bus ();

    lsu_mem_arbiter #(.NUM_REQ(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_ren    = '0;
        bus.req_wen    = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        for (int i = 0; i < 2; i++) begin
            bus.req_raddr[i] = '0;
            bus.req_waddr[i] = '0;
            bus.req_wdata[i] = '0;
        end
        tick();
        tick();
        check("rst_mem_ren", bus.mem_ren, 0);
        check("rst_mem_wen", bus.mem_wen, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_raddr", bus.mem_raddr, 0);
        check("rst_wack", bus.req_wack, 0);
        rst = 1'b0;

        // Single read, memory answers in the third mem_ren cycle.
        bus.req_ren[0]   = 1'b1;
        bus.req_raddr[0] = 64'h100;
        tick();
        check("rd_ren_c1", bus.mem_ren, 1);
        check("rd_addr", bus.mem_raddr, 64'h100);
        check("rd_busy", busy, 1);
        check("rd_rvalid_early", bus.req_rvalid, 0);
        tick();
        check("rd_ren_c2", bus.mem_ren, 1);
        tick();
        check("rd_ren_c3", bus.mem_ren, 1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'hDEAD;
        #1;
        check("rd_rvalid", bus.req_rvalid, 2'b01);
        check("rd_rdata0", bus.req_rdata[0], 64'hDEAD);
        bus.req_ren[0] = 1'b0;
        tick();
        bus.mem_rvalid = 1'b0;
        #1;
        check("rd_ren_drop", bus.mem_ren, 0);
        check("rd_idle", busy, 0);

        // Write contention straight out of reset.
        do_reset();
        bus.req_wen      = 2'b11;
        bus.req_waddr[0] = 64'h200;
        bus.req_wdata[0] = 64'h1111;
        bus.req_waddr[1] = 64'h300;
        bus.req_wdata[1] = 64'h2222;
        tick();
        check("wr0_wack", bus.req_wack, 2'b01);
        check("wr0_wen", bus.mem_wen, 1);
        check("wr0_addr", bus.mem_waddr, 64'h200);
        check("wr0_data", bus.mem_wdata, 64'h1111);
        check("wr0_grant", grant_id, 0);
        bus.req_wen[0] = 1'b0;
        tick();
        check("wr_gap_wen", bus.mem_wen, 0);
        check("wr_gap_wack", bus.req_wack, 0);
        tick();
        check("wr1_wack", bus.req_wack, 2'b10);
        check("wr1_addr", bus.mem_waddr, 64'h300);
        check("wr1_data", bus.mem_wdata, 64'h2222);
        check("wr1_grant", grant_id, 1);
        bus.req_wen[1] = 1'b0;
        tick();
        check("wr_done", busy, 0);

        // Fairness: both read continuously, 1-cycle memory latency.
        cnt0 = 0;
        cnt1 = 0;
        bus.req_raddr[0] = 64'hA0;
        bus.req_raddr[1] = 64'hB0;
        bus.req_ren      = 2'b11;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("fair_grant", grant_id, i % 2);
            check("fair_addr", bus.mem_raddr, (i % 2 == 0) ? 64'hA0 : 64'hB0);
            if (grant_id == 1'b0) cnt0++;
            else cnt1++;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 64'h9000 + 64'(i);
            #1;
            check("fair_rvalid", bus.req_rvalid, 2'b01 << (i % 2));
            if (i == 19) bus.req_ren = 2'b00;
            tick();
            bus.mem_rvalid = 1'b0;
        end
        check("fair_cnt0", cnt0, 10);
        check("fair_cnt1", cnt1, 10);
        tick();
        check("fair_idle", busy, 0);

        // Write priority: requester 1 asserts both.
        bus.req_ren[1]   = 1'b1;
        bus.req_wen[1]   = 1'b1;
        bus.req_raddr[1] = 64'hC0;
        bus.req_waddr[1] = 64'hC8;
        bus.req_wdata[1] = 64'h3333;
        tick();
        check("prio_wack", bus.req_wack, 2'b10);
        check("prio_no_ren", bus.mem_ren, 0);
        check("prio_waddr", bus.mem_waddr, 64'hC8);
        bus.req_wen[1] = 1'b0;
        tick();
        check("prio_gap", busy, 0);
        tick();
        check("prio_ren", bus.mem_ren, 1);
        check("prio_raddr", bus.mem_raddr, 64'hC0);
        check("prio_grant", grant_id, 1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'h4444;
        #1;
        check("prio_rvalid", bus.req_rvalid, 2'b10);
        check("prio_rdata1", bus.req_rdata[1], 64'h4444);
        bus.req_ren[1] = 1'b0;
        tick();
        bus.mem_rvalid = 1'b0;

        // Reset while a read from requester 1 is outstanding.
        bus.req_ren[1]   = 1'b1;
        bus.req_raddr[1] = 64'hE0;
        tick();
        check("mid_ren", bus.mem_ren, 1);
        check("mid_grant", grant_id, 1);
        rst            = 1'b1;
        bus.req_ren[1] = 1'b0;
        #1;
        check("mid_rst_ren", bus.mem_ren, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_grant", grant_id, 0);
        check("mid_rst_raddr", bus.mem_raddr, 0);
        check("mid_rst_wdata", bus.mem_wdata, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'h5555;
        #1;
        check("late_rvalid", bus.req_rvalid, 0);
        tick();
        check("late_busy", busy, 0);
        check("late_ren", bus.mem_ren, 0);
        bus.mem_rvalid = 1'b0;

        // Spurious mem_rvalid in IDLE.
        tick();
        bus.mem_rvalid = 1'b1;
        #1;
        check("spur_rvalid", bus.req_rvalid, 0);
        tick();
        check("spur_busy", busy, 0);
        check("spur_wack", bus.req_wack, 0);
        bus.mem_rvalid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
